// File: rtl/top_fsm_div_pkg.sv
// Shared types and constants for the top_fsm_div calculator: FSM states,
// 7-segment code table and display digit positions.
package top_fsm_div_pkg;

  typedef enum logic [1:0] {
    S_A    = 2'd0,
    S_B    = 2'd1,
    S_CALC = 2'd2,
    S_DONE = 2'd3
  } state_e;

  // Active-low {g,f,e,d,c,b,a}; entry n is the glyph for hex digit n.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
    7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
    7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
    7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
  };

  localparam logic [6:0] BLANK = 7'b1111111;

  localparam logic [2:0] OP_DIGIT  = 3'd0;
  localparam logic [2:0] ERR_DIGIT = 3'd4;
  localparam logic [2:0] RES_DIGIT = 3'd7;

  function automatic logic [6:0] seg_code(input logic [3:0] value);
    return SEG_TABLE[value];
  endfunction

endpackage

// File: rtl/div_seq_4.sv
// 4-bit unsigned restoring divider: one quotient bit per clk, done pulses
// one cycle after the fourth step with q holding the quotient.
module div_seq_4 (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [3:0] q,
  output logic       done
);

  logic       busy_q, busy_d;
  logic [2:0] cnt_q, cnt_d;
  logic [3:0] rem_q, rem_d;
  logic [3:0] quo_q, quo_d;
  logic [3:0] bd_q, bd_d;
  logic       done_q, done_d;
  logic [4:0] shifted_s;
  logic [3:0] diff_s;

  // Partial remainder with the next dividend bit shifted in; quo_q doubles as
  // the dividend shift register.
  assign shifted_s = {rem_q, quo_q[3]};
  assign diff_s    = shifted_s[3:0] - bd_q;

  // Next-state logic for one restoring step per cycle.
  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    rem_d  = rem_q;
    quo_d  = quo_q;
    bd_d   = bd_q;
    done_d = 1'b0;
    if (start) begin
      busy_d = 1'b1;
      cnt_d  = 3'd4;
      rem_d  = 4'd0;
      quo_d  = a;
      bd_d   = b;
    end else if (busy_q) begin
      if (shifted_s >= {1'b0, bd_q}) begin
        rem_d = diff_s;
        quo_d = {quo_q[2:0], 1'b1};
      end else begin
        rem_d = shifted_s[3:0];
        quo_d = {quo_q[2:0], 1'b0};
      end
      cnt_d = cnt_q - 3'd1;
      if (cnt_q == 3'd1) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end else begin
        busy_d = 1'b1;
      end
    end else begin
      busy_d = 1'b0;
    end
  end

  // Divider state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= 1'b0;
      cnt_q  <= 3'd0;
      rem_q  <= 4'd0;
      quo_q  <= 4'd0;
      bd_q   <= 4'd0;
      done_q <= 1'b0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      bd_q   <= bd_d;
      done_q <= done_d;
    end
  end

  assign q    = quo_q;
  assign done = done_q;

endmodule

// File: rtl/top_fsm_div.sv
// Board-level 4-bit divider calculator with debounced entry and 8-digit
// multiplexed display. Define SIGNED_DIV_EN for two's-complement operands.
module top_fsm_div
  import top_fsm_div_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = 16,
  parameter int SCAN_DIV       = 10000
) (
  input  logic       clk,
  input  logic       btn_reset_in,
  input  logic       btn_c_in,
  input  logic [3:0] SW,
  output logic [7:0] AN,
  output logic [6:0] CATH,
  output logic       valid_out_LED
);

  localparam int DB_W   = $clog2(DEBOUNCE_TICKS + 1);
  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic rst;
  assign rst = btn_reset_in;

  logic            sync1_q, sync2_q;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic            db_q, db_d, db_prev_q;
  logic            press_s;

  state_e     state_q, state_d;
  logic [3:0] a_q, a_d, b_q, b_d, opnd_q, opnd_d, quo_q, quo_d;
  logic       err_q, err_d, valid_q, valid_d, start_q, start_d;

  logic [3:0] a_mag_s, b_mag_s, div_q_s, quo_res_s;
  logic       div_err_s, div_done_s;

  logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
  logic [2:0]        idx_q, idx_d;
  logic [7:0]        an_q, an_d;
  logic [6:0]        cath_q, cath_d;

  // Debounce: level follows the synchronized input only after a full run of
  // DEBOUNCE_TICKS consecutive samples that disagree with it.
  always_comb begin
    db_cnt_d = '0;
    db_d     = db_q;
    if (sync2_q != db_q) begin
      if (db_cnt_q == DB_W'(DEBOUNCE_TICKS - 1)) begin
        db_d     = sync2_q;
        db_cnt_d = '0;
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end else begin
      db_cnt_d = '0;
    end
  end

  assign press_s = db_q & ~db_prev_q;

  // Synchronizer and debouncer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      db_cnt_q  <= '0;
      db_q      <= 1'b0;
      db_prev_q <= 1'b0;
    end else begin
      sync1_q   <= btn_c_in;
      sync2_q   <= sync1_q;
      db_cnt_q  <= db_cnt_d;
      db_q      <= db_d;
      db_prev_q <= db_q;
    end
  end

`ifdef SIGNED_DIV_EN
  logic neg_s;
  assign a_mag_s   = a_q[3] ? (4'd0 - a_q) : a_q;
  assign b_mag_s   = b_q[3] ? (4'd0 - b_q) : b_q;
  assign neg_s     = a_q[3] ^ b_q[3];
  assign div_err_s = (b_q == 4'd0) || ((a_q == 4'h8) && (b_q == 4'hF));
  assign quo_res_s = neg_s ? (4'd0 - div_q_s) : div_q_s;
`else
  assign a_mag_s   = a_q;
  assign b_mag_s   = b_q;
  assign div_err_s = (b_q == 4'd0);
  assign quo_res_s = div_q_s;
`endif

  div_seq_4 u_div (
    .clk  (clk),
    .rst  (rst),
    .start(start_q & ~div_err_s),
    .a    (a_mag_s),
    .b    (b_mag_s),
    .q    (div_q_s),
    .done (div_done_s)
  );

  // Calculator FSM next-state and datapath updates.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    opnd_d  = opnd_q;
    quo_d   = quo_q;
    err_d   = err_q;
    valid_d = valid_q;
    start_d = 1'b0;
    case (state_q)
      S_A: begin
        if (press_s) begin
          a_d     = SW;
          opnd_d  = SW;
          state_d = S_B;
        end else begin
          state_d = S_A;
        end
      end
      S_B: begin
        if (press_s) begin
          b_d     = SW;
          opnd_d  = SW;
          start_d = 1'b1;
          state_d = S_CALC;
        end else begin
          state_d = S_B;
        end
      end
      S_CALC: begin
        if (div_err_s) begin
          quo_d   = 4'd0;
          err_d   = 1'b1;
          valid_d = 1'b1;
          state_d = S_DONE;
        end else if (div_done_s) begin
          quo_d   = quo_res_s;
          err_d   = 1'b0;
          valid_d = 1'b1;
          state_d = S_DONE;
        end else begin
          state_d = S_CALC;
        end
      end
      S_DONE: begin
        if (press_s) begin
          quo_d   = 4'd0;
          err_d   = 1'b0;
          valid_d = 1'b0;
          opnd_d  = 4'd0;
          state_d = S_A;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_A;
      end
    endcase
  end

  // FSM and operand/result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_A;
      a_q     <= 4'd0;
      b_q     <= 4'd0;
      opnd_q  <= 4'd0;
      quo_q   <= 4'd0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      opnd_q  <= opnd_d;
      quo_q   <= quo_d;
      err_q   <= err_d;
      valid_q <= valid_d;
      start_q <= start_d;
    end
  end

  // Scan timing and digit selection; anode and segments come from the same
  // index so they always change together.
  always_comb begin
    scan_cnt_d = scan_cnt_q + SCAN_W'(1);
    idx_d      = idx_q;
    if (scan_cnt_q == SCAN_W'(SCAN_DIV - 1)) begin
      scan_cnt_d = '0;
      idx_d      = idx_q + 3'd1;
    end else begin
      idx_d = idx_q;
    end
    an_d = ~(8'b0000_0001 << idx_q);
    case (idx_q)
      OP_DIGIT:  cath_d = seg_code(opnd_q);
      ERR_DIGIT: cath_d = seg_code({3'b000, err_q});
      RES_DIGIT: cath_d = seg_code(quo_q);
      default:   cath_d = BLANK;
    endcase
  end

  // Display registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt_q <= '0;
      idx_q      <= 3'd0;
      an_q       <= 8'b1111_1110;
      cath_q     <= seg_code(4'd0);
    end else begin
      scan_cnt_q <= scan_cnt_d;
      idx_q      <= idx_d;
      an_q       <= an_d;
      cath_q     <= cath_d;
    end
  end

  assign AN            = an_q;
  assign CATH          = cath_q;
  assign valid_out_LED = valid_q;

endmodule

// File: tb/tb_top_fsm_div.sv
// Self-checking bench for top_fsm_div: randomized operand pairs against a
// behavioural calculator model, plus bounce, scan and mid-calculation reset.
module tb_top_fsm_div;
  import top_fsm_div_pkg::*;

  localparam int SCAN = 20;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn;
  logic [3:0] sw;
  logic [7:0] AN;
  logic [6:0] CATH;
  logic       valid;

  int errors = 0;
  int checks = 0;

  // Behavioural model: phase 0 = entering A, 1 = entering B, 2 = result shown.
  int m_phase, m_a, m_b, m_opnd, m_q, m_err, m_valid;

  top_fsm_div #(.DEBOUNCE_TICKS(16), .SCAN_DIV(SCAN)) dut (
    .clk          (clk),
    .btn_reset_in (rst),
    .btn_c_in     (btn),
    .SW           (sw),
    .AN           (AN),
    .CATH         (CATH),
    .valid_out_LED(valid)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] seg7(input int v);
    case (v & 15)
      0: return 7'b1000000;   1: return 7'b1111001;
      2: return 7'b0100100;   3: return 7'b0110000;
      4: return 7'b0011001;   5: return 7'b0010010;
      6: return 7'b0000010;   7: return 7'b1111000;
      8: return 7'b0000000;   9: return 7'b0010000;
      10: return 7'b0001000;  11: return 7'b0000011;
      12: return 7'b1000110;  13: return 7'b0100001;
      14: return 7'b0000110;  default: return 7'b0001110;
    endcase
  endfunction

  task automatic model_reset();
    m_phase = 0; m_a = 0; m_b = 0; m_opnd = 0; m_q = 0; m_err = 0; m_valid = 0;
  endtask

  task automatic model_divide();
`ifdef SIGNED_DIV_EN
    int sa, sb;
    sa = (m_a > 7) ? m_a - 16 : m_a;
    sb = (m_b > 7) ? m_b - 16 : m_b;
    if (sb == 0 || (sa == -8 && sb == -1)) begin m_err = 1; m_q = 0; end
    else begin m_err = 0; m_q = (sa / sb) & 15; end
`else
    if (m_b == 0) begin m_err = 1; m_q = 0; end
    else begin m_err = 0; m_q = m_a / m_b; end
`endif
  endtask

  task automatic model_press(input int v);
    if (m_phase == 0) begin m_a = v; m_opnd = v; m_phase = 1; end
    else if (m_phase == 1) begin m_b = v; m_opnd = v; model_divide(); m_valid = 1; m_phase = 2; end
    else begin m_q = 0; m_err = 0; m_valid = 0; m_opnd = 0; m_phase = 0; end
  endtask

  task automatic press(input logic [3:0] v);
    sw = v;
    @(negedge clk); btn = 1'b1;
    repeat (34) @(negedge clk);
    btn = 1'b0;
    repeat (34) @(negedge clk);
    model_press(int'(v));
  endtask

  task automatic read_digit(input int idx, output logic [6:0] c);
    logic [7:0] tgt;
    int n;
    tgt = ~(8'b0000_0001 << idx);
    n = 0;
    @(negedge clk);
    while (AN !== tgt && n < 20 * SCAN) begin @(negedge clk); n++; end
    if (AN !== tgt) begin
      checks++; errors++;
      $display("FAIL scan_timeout digit %0d: AN=%b expected %b", idx, AN, tgt);
    end
    c = CATH;
  endtask

  task automatic test_reset();
    rst = 1'b1; btn = 1'b0; sw = 4'd0;
    repeat (3) @(negedge clk);
    checks++; if (AN !== 8'b1111_1110) begin errors++; $display("FAIL reset_an: got %b expected 11111110", AN); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid); end
    checks++; if (CATH !== 7'b1000000) begin errors++; $display("FAIL reset_cath: got %b expected 1000000", CATH); end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_basic();
    logic [6:0] c;
    press(4'd6);
    read_digit(0, c);
    checks++; if (c !== 7'b0000010) begin errors++; $display("FAIL basic_opa: got %b expected 0000010", c); end
    press(4'd3);
    read_digit(0, c);
    checks++; if (c !== 7'b0110000) begin errors++; $display("FAIL basic_opb: got %b expected 0110000", c); end
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b expected 1", valid); end
    read_digit(7, c);
    checks++; if (c !== 7'b0100100) begin errors++; $display("FAIL basic_quot: got %b expected 0100100", c); end
    read_digit(4, c);
    checks++; if (c !== 7'b1000000) begin errors++; $display("FAIL basic_err: got %b expected 1000000", c); end
    press(4'd9);
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL clear_valid: got %b expected 0", valid); end
    read_digit(7, c);
    checks++; if (c !== 7'b1000000) begin errors++; $display("FAIL clear_quot: got %b expected 1000000", c); end
    read_digit(4, c);
    checks++; if (c !== 7'b1000000) begin errors++; $display("FAIL clear_err: got %b expected 1000000", c); end
  endtask

  task automatic test_div_zero();
    logic [6:0] c;
    press(4'd3);
    press(4'd0);
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL dz_valid: got %b expected 1", valid); end
    read_digit(4, c);
    checks++; if (c !== 7'b1111001) begin errors++; $display("FAIL dz_err: got %b expected 1111001", c); end
    read_digit(7, c);
    checks++; if (c !== 7'b1000000) begin errors++; $display("FAIL dz_quot: got %b expected 1000000", c); end
    press(4'd0);
    read_digit(4, c);
    checks++; if (c !== 7'b1000000) begin errors++; $display("FAIL dz_clear: got %b expected 1000000", c); end
  endtask

  task automatic test_random();
    logic [6:0] c;
    logic [3:0] a, b;
    for (int i = 0; i < 10; i++) begin
      a = 4'($urandom_range(0, 15));
      b = (i % 4 == 3) ? 4'd0 : 4'($urandom_range(0, 15));
      press(a);
      press(b);
      read_digit(0, c);
      checks++; if (c !== seg7(m_opnd)) begin errors++; $display("FAIL rnd_op %0d/%0d: got %b expected %b", a, b, c, seg7(m_opnd)); end
      read_digit(7, c);
      checks++; if (c !== seg7(m_q)) begin errors++; $display("FAIL rnd_quot %0d/%0d: got %b expected %b", a, b, c, seg7(m_q)); end
      read_digit(4, c);
      checks++; if (c !== seg7(m_err)) begin errors++; $display("FAIL rnd_err %0d/%0d: got %b expected %b", a, b, c, seg7(m_err)); end
      checks++; if (valid !== 1'(m_valid)) begin errors++; $display("FAIL rnd_valid %0d/%0d: got %b expected %0d", a, b, valid, m_valid); end
      press(4'($urandom_range(0, 15)));
      checks++; if (valid !== 1'(m_valid)) begin errors++; $display("FAIL rnd_clear: got %b expected %0d", valid, m_valid); end
    end
  endtask

  task automatic test_bounce();
    logic [6:0] c;
    sw = 4'd5;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); btn = (i % 2 == 0);
      repeat (2) @(negedge clk);
    end
    btn = 1'b1;
    repeat (34) @(negedge clk);
    btn = 1'b0;
    repeat (34) @(negedge clk);
    model_press(5);
    read_digit(0, c);
    checks++; if (c !== seg7(m_opnd)) begin errors++; $display("FAIL bounce_op: got %b expected %b", c, seg7(m_opnd)); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL bounce_valid: got %b expected 0", valid); end
    sw = 4'd2;
    @(negedge clk); btn = 1'b1;
    repeat (10) @(negedge clk);
    btn = 1'b0;
    repeat (40) @(negedge clk);
    read_digit(0, c);
    checks++; if (c !== seg7(m_opnd)) begin errors++; $display("FAIL glitch_op: got %b expected %b", c, seg7(m_opnd)); end
    press(4'd1);
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL bounce_done: got %b expected 1", valid); end
    read_digit(7, c);
    checks++; if (c !== seg7(m_q)) begin errors++; $display("FAIL bounce_quot: got %b expected %b", c, seg7(m_q)); end
    press(4'd0);
  endtask

  task automatic test_scan();
    logic [6:0] c;
    logic [7:0] prev;
    int n, k;
    read_digit(0, c);
    prev = AN; n = 0;
    while (AN === prev && n < 4 * SCAN) begin @(negedge clk); n++; end
    checks++; if (AN !== 8'b1111_1101) begin errors++; $display("FAIL scan_first: got %b expected 11111101", AN); end
    for (k = 2; k <= 9; k++) begin
      prev = AN; n = 0;
      while (AN === prev && n < 4 * SCAN) begin @(negedge clk); n++; end
      checks++; if (n != SCAN) begin errors++; $display("FAIL scan_period step %0d: got %0d expected %0d", k, n, SCAN); end
      checks++; if (AN !== ~(8'b0000_0001 << (k % 8))) begin errors++; $display("FAIL scan_an step %0d: got %b", k, AN); end
      if ((k % 8) inside {1, 2, 3, 5, 6}) begin
        checks++; if (CATH !== 7'b1111111) begin errors++; $display("FAIL scan_blank step %0d: got %b expected 1111111", k, CATH); end
      end
    end
  endtask

  task automatic test_reset_in_calc();
    logic [6:0] c;
    int n;
    press(4'd7);
    sw = 4'd2;
    @(negedge clk); btn = 1'b1;
    n = 0;
    while (dut.state_q != S_CALC && n < 200) begin @(negedge clk); n++; end
    checks++; if (dut.state_q != S_CALC) begin errors++; $display("FAIL calc_reach: state=%0d expected S_CALC", dut.state_q); end
    rst = 1'b1;
    #1;
    checks++; if (AN !== 8'b1111_1110) begin errors++; $display("FAIL calc_rst_an: got %b expected 11111110", AN); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL calc_rst_valid: got %b expected 0", valid); end
    checks++; if (dut.state_q != S_A) begin errors++; $display("FAIL calc_rst_state: got %0d expected S_A", dut.state_q); end
    btn = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();
    press(4'd4);
    read_digit(0, c);
    checks++; if (c !== 7'b0011001) begin errors++; $display("FAIL post_rst_op: got %b expected 0011001", c); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL post_rst_valid: got %b expected 0", valid); end
    press(4'd2);
    read_digit(7, c);
    checks++; if (c !== 7'b0100100) begin errors++; $display("FAIL post_rst_quot: got %b expected 0100100", c); end
    press(4'd0);
  endtask

`ifdef SIGNED_DIV_EN
  task automatic test_signed();
    logic [6:0] c;
    press(4'h8);
    press(4'hF);
    read_digit(4, c);
    checks++; if (c !== 7'b1111001) begin errors++; $display("FAIL sgn_ovf_err: got %b expected 1111001", c); end
    read_digit(7, c);
    checks++; if (c !== 7'b1000000) begin errors++; $display("FAIL sgn_ovf_quot: got %b expected 1000000", c); end
    press(4'd0);
    press(4'h9);
    press(4'h2);
    read_digit(7, c);
    checks++; if (c !== 7'b0100001) begin errors++; $display("FAIL sgn_m7_2: got %b expected 0100001", c); end
    press(4'd0);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_div_zero();
    test_random();
    test_bounce();
    test_scan();
    test_reset_in_calc();
`ifdef SIGNED_DIV_EN
    test_signed();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
